// File: rtl/joy_pkg.sv
// joy_pkg: FSM states, MCP3008 command constants and frame helpers for joy_adc_scanner
package joy_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE} joy_state_e;
  localparam int START_BIT = 1;
  localparam int SGL_BIT = 1;
  localparam int CMD_BITS = 5;
  localparam int NULL_BITS = 1;
  function automatic int frame_bits(input int adc_bits);
    return CMD_BITS + NULL_BITS + adc_bits;
  endfunction
  function automatic logic cmd_bit(input int p, input logic [2:0] ch);
    return p == 0 ? START_BIT[0] : p == 1 ? SGL_BIT[0] : p < CMD_BITS ? ch[2'(4 - p)] : 1'b0;
  endfunction
endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: synchronise, invert and debounce one active-low switch
module joy_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  output logic state,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_n;
  logic [CW-1:0] cnt;
  logic raw;
  logic accept;
  assign raw = ~sync_n[1];
  assign accept = raw != state && cnt == LAST;
  // two-flop synchroniser; the released level is high
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_n <= '1;
    else sync_n <= {sync_n[0], sw_n};
  // count consecutive cycles differing from the accepted state; the counter stops at LAST
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= 1'b0;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      press <= accept && raw;
      state <= accept ? raw : state;
      cnt <= (raw == state || accept) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/joy_adc_scanner.sv
// joy_adc_scanner: scans NUM_AXES channels of an MCP3008-style SPI ADC and debounces buttons; JOY_DEADZONE_EN enables centre snapping
module joy_adc_scanner import joy_pkg::*; #(
  parameter int NUM_AXES = 2,
  parameter int ADC_BITS = 10,
  parameter int SCLK_DIV = 4,
  parameter int NUM_BUTTONS = 1,
`ifdef JOY_DEADZONE_EN
  parameter int DEADZONE = 8,
`endif
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         adc_cs_n,
  output logic                         adc_sclk,
  output logic                         adc_mosi,
  input  logic                         adc_miso,
  input  logic [NUM_BUTTONS-1:0]       joy_sw_n,
  output logic [NUM_AXES*ADC_BITS-1:0] axis_data,
  output logic                         frame_valid,
  output logic [NUM_BUTTONS-1:0]       buttons,
  output logic [NUM_BUTTONS-1:0]       button_press
);
  localparam int FB = frame_bits(ADC_BITS);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(FB);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);
  localparam logic [BW-1:0] BIT_DATA = BW'(CMD_BITS + NULL_BITS);
  localparam logic [2:0] CH_LAST = 3'(NUM_AXES - 1);
`ifdef JOY_DEADZONE_EN
  localparam int AW = ADC_BITS + 1;
  localparam logic signed [AW-1:0] MID = AW'(1 << (ADC_BITS - 1));
  localparam logic signed [AW-1:0] DZ = AW'(DEADZONE);
  function automatic logic [ADC_BITS-1:0] snap(input logic [ADC_BITS-1:0] v);
    logic signed [AW-1:0] d;
    d = $signed({1'b0, v}) - MID;
    return (d <= DZ && d >= -DZ) ? MID[ADC_BITS-1:0] : v;
  endfunction
`endif
  joy_state_e state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [2:0] ch;
  logic sclk_q;
  logic tick;
  logic [ADC_BITS-1:0] sh;
  logic [ADC_BITS-1:0] shadow [NUM_AXES];
  logic [NUM_AXES*ADC_BITS-1:0] pub;
  assign tick = div_cnt == DIV_LAST;
  assign adc_sclk = sclk_q;
  // state register; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state; enable only matters at frame boundaries
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = enable ? CS_SETUP : IDLE;
      CS_SETUP: state_nx = tick ? SHIFT : CS_SETUP;
      SHIFT:    state_nx = (tick && sclk_q && bit_cnt == BIT_LAST) ? CS_HOLD : SHIFT;
      CS_HOLD:  state_nx = !tick ? CS_HOLD : ch == CH_LAST ? UPDATE : enable ? CS_SETUP : IDLE;
      UPDATE:   state_nx = enable ? CS_SETUP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // chip select and command bits, which only move while SCLK is low
  always_comb begin
    adc_cs_n = !(state == CS_SETUP || state == SHIFT);
    adc_mosi = !adc_cs_n && cmd_bit(int'(bit_cnt), ch);
  end
  // published values, optionally snapped to the centre
  always_comb begin
    pub = '0;
    for (int k = 0; k < NUM_AXES; k++)
`ifdef JOY_DEADZONE_EN
      pub[k*ADC_BITS +: ADC_BITS] = snap(shadow[k]);
`else
      pub[k*ADC_BITS +: ADC_BITS] = shadow[k];
`endif
  end
  // SCLK generation, MISO capture, per-channel shadows and the coherent snapshot
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      ch <= '0;
      sclk_q <= 1'b0;
      sh <= '0;
      axis_data <= '0;
      frame_valid <= 1'b0;
      for (int k = 0; k < NUM_AXES; k++) shadow[k] <= '0;
    end else begin
      div_cnt <= ((state == CS_SETUP || state == SHIFT || state == CS_HOLD) && !tick) ? div_cnt + 1'b1 : '0;
      sclk_q <= state == SHIFT && (tick ? !sclk_q : sclk_q);
      bit_cnt <= state != SHIFT ? '0 : (tick && sclk_q) ? bit_cnt + 1'b1 : bit_cnt;
      sh <= (state == SHIFT && tick && !sclk_q && bit_cnt >= BIT_DATA) ? ADC_BITS'({sh, adc_miso}) : sh;
      ch <= state == UPDATE ? '0 : (state == CS_HOLD && tick && ch != CH_LAST) ? ch + 1'b1 : ch;
      for (int k = 0; k < NUM_AXES; k++) shadow[k] <= (state == CS_HOLD && tick && ch == 3'(k)) ? sh : shadow[k];
      frame_valid <= state == UPDATE;
      axis_data <= state == UPDATE ? pub : axis_data;
    end
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    joy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .sw_n(joy_sw_n[i]),
      .state(buttons[i]),
      .press(button_press[i])
    );
  end
endmodule

// File: tb/tb_joy_adc_scanner.sv
// tb_joy_adc_scanner: directed checks of the joystick ADC scanner with an MCP3008 slave model
module tb_joy_adc_scanner;
  localparam int FB = 16;
  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic adc_cs_n, adc_sclk, adc_mosi, adc_miso;
  logic [0:0] joy_sw_n;
  logic [19:0] axis_data;
  logic frame_valid;
  logic [0:0] buttons, button_press;
  int tests = 0;
  int fails = 0;

  joy_adc_scanner #(
    .NUM_AXES(2), .ADC_BITS(10), .SCLK_DIV(4), .NUM_BUTTONS(1), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
    .joy_sw_n(joy_sw_n), .axis_data(axis_data), .frame_valid(frame_valid),
    .buttons(buttons), .button_press(button_press)
  );

  always #5 clk = ~clk;

  logic [9:0] resp [8];
  logic [4:0] cmd = '0;
  int rise_cnt = 0;
  logic [2:0] cur_ch = '0;
  logic [4:0] cmd_q [$];
  int sclk_edges = 0;

  // ADC slave: decode the command from MOSI, return resp[channel] MSB first
  always @(posedge adc_sclk or negedge adc_cs_n)
    if (!adc_sclk) rise_cnt = 0;
    else begin
      cmd = {cmd[3:0], adc_mosi};
      rise_cnt++;
      sclk_edges++;
      if (rise_cnt == 5) begin
        cur_ch = cmd[2:0];
        cmd_q.push_back(cmd);
      end
    end
  assign adc_miso = (rise_cnt >= 6 && rise_cnt < FB) ? resp[cur_ch][FB - 1 - rise_cnt] : 1'b0;

  int fv_cnt = 0, press_cnt = 0;
  logic fv_prev = 1'b0, fv_double = 1'b0, bouncing = 1'b0, bounce_bad = 1'b0;
  // event monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_valid && fv_prev) fv_double = 1'b1;
    fv_prev = frame_valid;
    if (button_press[0]) press_cnt++;
    if (bouncing && buttons[0]) bounce_bad = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fv(output int n);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (frame_valid) break;
    end
    tests++;
    if (!frame_valid) begin
      fails++;
      $display("FAIL fv_timeout: got no frame_valid expected pulse within 1000 cycles");
    end
  endtask

  typedef struct {
    logic [9:0] r0, r1, e0, e1;
  } vec_t;
  vec_t vt [5];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, qn, fvs, p0, k;
    vt[0] = '{10'h3FF, 10'h155, 10'h3FF, 10'h155};
`ifdef JOY_DEADZONE_EN
    vt[1] = '{10'h205, 10'h1F8, 10'h200, 10'h200};
    vt[3] = '{10'h208, 10'h1FF, 10'h200, 10'h200};
`else
    vt[1] = '{10'h205, 10'h1F8, 10'h205, 10'h1F8};
    vt[3] = '{10'h208, 10'h1FF, 10'h208, 10'h1FF};
`endif
    vt[2] = '{10'h209, 10'h1F7, 10'h209, 10'h1F7};
    vt[4] = '{10'h000, 10'h2AA, 10'h000, 10'h2AA};
    for (int i = 0; i < 8; i++) resp[i] = '0;
    rst = 1'b0;
    enable = 1'b0;
    joy_sw_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_mosi", adc_mosi, 0);
    check("rst_axis", axis_data, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_buttons", {buttons, button_press}, 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_sclk_edges", sclk_edges, 0);
    check("idle_cs_n", adc_cs_n, 1);
    check("idle_axis", axis_data, 0);

    resp[0] = vt[0].r0;
    resp[1] = vt[0].r1;
    enable = 1'b1;
    wait_fv(n);
    check("scan0_axis", axis_data, {vt[0].e1, vt[0].e0});
    check("scan0_cmd_ch0", cmd_q[0], 5'b11000);
    check("scan0_cmd_ch1", cmd_q[1], 5'b11001);
    for (int i = 1; i < 5; i++) begin
      resp[0] = vt[i].r0;
      resp[1] = vt[i].r1;
      wait_fv(n);
      check($sformatf("vec%0d_period", i), n, 273);
      check($sformatf("vec%0d_axis", i), axis_data, {vt[i].e1, vt[i].e0});
    end
    check("fv_one_cycle", fv_double, 0);

    qn = cmd_q.size();
    repeat (50) @(negedge clk);
    enable = 1'b0;
    fvs = fv_cnt;
    repeat (300) @(negedge clk);
    check("drop_frames", cmd_q.size(), qn + 1);
    check("drop_cmd_ch0", cmd_q[qn], 5'b11000);
    check("drop_cs_n", adc_cs_n, 1);
    check("drop_no_fv", fv_cnt, fvs);
    check("drop_axis_kept", axis_data, {10'h2AA, 10'h000});
    resp[0] = 10'h111;
    resp[1] = 10'h222;
    enable = 1'b1;
    wait_fv(n);
    check("resume_cmd_ch1", cmd_q[qn + 1], 5'b11001);
    check("resume_frames", cmd_q.size(), qn + 2);
    check("resume_axis", axis_data, {10'h222, 10'h000});

    k = 0;
    while (!(cur_ch == 3'd1 && rise_cnt == 8) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_p8", k < 1000, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_cs_n_async", adc_cs_n, 1);
    check("abort_sclk_async", adc_sclk, 0);
    repeat (3) @(negedge clk);
    check("abort_axis_cleared", axis_data, 0);
    qn = cmd_q.size();
    rst = 1'b1;
    wait_fv(n);
    check("restart_latency", n, 274);
    check("restart_cmd_ch0", cmd_q[qn], 5'b11000);
    check("restart_cmd_ch1", cmd_q[qn + 1], 5'b11001);
    check("restart_axis", axis_data, {10'h222, 10'h111});

    enable = 1'b0;
    p0 = press_cnt;
    bouncing = 1'b1;
    for (int i = 0; i < 12; i++) begin
      joy_sw_n = ~joy_sw_n;
      repeat (5) @(negedge clk);
    end
    joy_sw_n = 1'b0;
    bouncing = 1'b0;
    check("bounce_rejected", bounce_bad, 0);
    n = 0;
    while (!buttons[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("press_latency", n, 18);
    check("press_pulse_same_cycle", button_press, 1);
    repeat (5) @(negedge clk);
    check("press_once", press_cnt - p0, 1);
    check("press_pulse_ends", button_press, 0);
    p0 = press_cnt;
    joy_sw_n = 1'b1;
    repeat (40) @(negedge clk);
    check("release_state", buttons, 0);
    check("release_no_pulse", press_cnt - p0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/joy_adc_scanner.md
Name: joy_adc_scanner

Overview:
- Parametrised successor to the single-pair joystick sampler: scans NUM_AXES analog axes through an external MCP3008-style SPI ADC and debounces NUM_BUTTONS switches.
- Publishes a coherent snapshot of all axes with a one-cycle valid strobe.
- Sits between the board ADC/switch pins and the game/control logic.

Parameters:
- NUM_AXES, 2, channels scanned, 1..8; axis k uses ADC channel k.
- ADC_BITS, 10, conversion width, 1..10.
- SCLK_DIV, 4, system clocks per SCLK half-period, minimum 2.
- NUM_BUTTONS, 1, debounced switch inputs.
- DEBOUNCE_CYCLES, 16, stable cycles needed before a button change is accepted, minimum 2.
- DEADZONE, 8, half-width of the centre snap window; used only with JOY_DEADZONE_EN.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset. One clock; reset is asynchronous and active-low.
- enable, in, 1, scanning allowed.
- adc_cs_n, out, 1, ADC chip select, active-low.
- adc_sclk, out, 1, SPI clock, idles low (mode 0).
- adc_mosi, out, 1, command bits to the ADC.
- adc_miso, in, 1, data bits from the ADC.
- joy_sw_n, in, NUM_BUTTONS, raw switches, active-low and asynchronous.
- axis_data, out, NUM_AXES*ADC_BITS, axis k is in bits [k*ADC_BITS +: ADC_BITS].
- frame_valid, out, 1, one-cycle pulse when axis_data updates.
- buttons, out, NUM_BUTTONS, debounced state, active-high.
- button_press, out, NUM_BUTTONS, one-cycle pulse on each debounced 0->1 transition.

Behaviour:
- Reset values:
  - adc_cs_n=1, adc_sclk=0, adc_mosi=0.
  - axis_data=0, frame_valid=0, buttons=0, button_press=0.
  - Channel index = 0, FSM state = IDLE.
- Reset asserted mid-frame:
  - adc_cs_n goes high and adc_sclk goes low immediately (asynchronous).
  - The partial scan is discarded.
- SPI frame:
  - Length is FRAME_BITS = 6+ADC_BITS SCLK periods.
  - MOSI is updated while SCLK is low. Periods 0..4 carry 1, 1, ch[2], ch[1], ch[0]. MOSI is 0 otherwise.
  - MISO is sampled on the SCLK rising edge in periods 6..FRAME_BITS-1, MSB first.
- FSM states:
  - IDLE: adc_cs_n=1. Goes to CS_SETUP when enable=1.
  - CS_SETUP: adc_cs_n=0, SCLK low for SCLK_DIV cycles, then SHIFT.
  - SHIFT: runs FRAME_BITS SCLK periods; each half-period is SCLK_DIV cycles.
  - CS_HOLD: adc_cs_n=1 for SCLK_DIV cycles. The sample goes into shadow register [ch].
    - If ch < NUM_AXES-1: ch++, then CS_SETUP (or IDLE if enable=0).
    - Otherwise: UPDATE.
  - UPDATE: 1 cycle. Copy all shadow registers to axis_data, pulse frame_valid, set ch=0, then CS_SETUP (or IDLE if enable=0).
- Timing:
  - Frame period per axis = SCLK_DIV*(2*FRAME_BITS+2) cycles.
  - Full scan = NUM_AXES frame periods + 1 cycle.
- enable:
  - Sampled only at frame boundaries; a frame already started always completes.
  - When enable drops mid-scan, the scan stops after the current frame. ch is retained and the scan resumes at that channel.
  - axis_data updates only after all axes of a scan are captured, so outputs are never mixed across scans.
- Buttons:
  - 2-FF synchroniser, then inversion.
  - A change is accepted once the input has been stable for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the counter.
  - The debounce counter saturates; it never wraps.
  - button_press pulses in the same cycle buttons rises.
  - Release produces no pulse.
  - Buttons run independently of enable and the FSM.

Optional Feature:
- Macro: JOY_DEADZONE_EN.
- Defined: at UPDATE, any sample v with |v - 2^(ADC_BITS-1)| <= DEADZONE is replaced by exactly 2^(ADC_BITS-1).
  - The comparison is done at ADC_BITS+1 bits, signed.
  - Values outside the window pass unchanged.
- Undefined: samples are published raw. No DEADZONE logic is generated.

Decomposition:
- Package joy_pkg:
  - FSM state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE).
  - Command constants START_BIT=1, SGL_BIT=1, CMD_BITS=5, NULL_BITS=1.
  - FRAME_BITS function of ADC_BITS.
- Sub-module joy_debounce (one bit, parameter DEBOUNCE_CYCLES; outputs state and press).
  - Instantiated NUM_BUTTONS times via generate.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release with enable=0. Expect adc_cs_n=1, adc_sclk=0, all outputs 0, and no SCLK edges for 100 cycles.
- Two-axis scan (SPI model returns 0x3FF on ch0 and 0x155 on ch1; SCLK_DIV=4):
  - MOSI reads 11000, then 11001.
  - frame_valid pulses once with axis_data = {0x155, 0x3FF}.
  - Next pulse follows 2*4*(2*16+2)+1 = 273 cycles after the first.
- Reset mid-SHIFT (rst=0 at SCLK period 8): adc_cs_n goes high asynchronously. After release, the scan restarts at ch0 with no frame_valid for the aborted scan.
- enable drop during a ch0 frame: the ch0 frame completes, the FSM goes IDLE with ch=1, and axis_data stays unchanged. Re-enable: the next frame addresses ch1, then frame_valid pulses.
- Button bounce (DEBOUNCE_CYCLES=16): toggle joy_sw_n every 5 cycles for 60 cycles, then hold 0. buttons rises 18 cycles after the final edge (2 synchroniser + 16), with one button_press pulse. Release gives no pulse.
- JOY_DEADZONE_EN with DEADZONE=8:
  - Samples 0x205 and 0x1F8 publish as 0x200.
  - Samples 0x209 and 0x1F7 pass unchanged.
  - Without the macro, 0x205 passes unchanged.
